// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU operation sequencer.
//   alu_op_e     - 6-bit ALU control codes understood by the shared ALU
//   ALU_NOP      - idle control code; the ALU returns 0 for it
//   seq_state_e  - sequencer FSM states
//   is_legal_op  - true for codes the ALU actually implements
package alu_pkg;

  typedef enum logic [5:0] {
    ALU_ADD   = 6'h00, ALU_SUB   = 6'h01, ALU_SLL   = 6'h02, ALU_SLT   = 6'h03,
    ALU_SLTU  = 6'h04, ALU_XOR   = 6'h05, ALU_SRL   = 6'h06, ALU_SRA   = 6'h07,
    ALU_OR    = 6'h08, ALU_AND   = 6'h09, ALU_ADDI  = 6'h0A, ALU_SLLI  = 6'h0B,
    ALU_SLTI  = 6'h0C, ALU_SLTIU = 6'h0D, ALU_XORI  = 6'h0E, ALU_SRLI  = 6'h0F,
    ALU_ORI   = 6'h10, ALU_ANDI  = 6'h11, ALU_LUI   = 6'h12,
    ALU_BEQ   = 6'h1A, ALU_BNE   = 6'h1B, ALU_BLT   = 6'h1C, ALU_BGE   = 6'h1D
  } alu_op_e;

  localparam logic [5:0] ALU_NOP = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  // Two contiguous legal ranges: 0x00-0x12 and 0x1A-0x1D.
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op <= 6'h12) || ((op >= 6'h1A) && (op <= 6'h1D));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant.
//   clk, rst_n  - clock, synchronous active-low reset
//   req_i[1:0]  - request vector
//   hs_i        - grant was taken this cycle; remember the winner
//   gnt_o[1:0]  - one-hot grant (zero when nothing requests)
// On a tie the port that did not win last time is granted. last_q resets
// to 1 so port 0 takes the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       hs_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Only a real handshake moves priority; a grant that is not taken
  // (e.g. outside IDLE) must not rotate it.
  assign last_d = hs_i ? gnt_o[1] : last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: shares one combinational ALU between two requesters
// (port 0 = execute path, port 1 = debug/CSR). One operation in flight.
//   clk, rst_n                 - clock, synchronous active-low reset
//   req_valid/req_ready[1:0]   - request handshake per port
//   req_op/src1/src2/imm/shamt - operation per port (held while valid)
//   rsp_valid[1:0]/rsp_ready   - response handshake, only owner bit set
//   rsp_data, rsp_err          - captured result / illegal-opcode flag
//   alu_*                      - drive the shared ALU (NOP unless EXEC)
//   alu_result                 - ALU result input
//   busy                       - state is not IDLE
// Flow: IDLE --accept--> EXEC (ALU driven, result captured) --> RESP
// (held until owner's rsp_ready) --> IDLE.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int OP_W    = 6,
  parameter int SHAMT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [1:0][OP_W-1:0]         req_op,
  input  logic [1:0][XLEN-1:0]         req_src1,
  input  logic [1:0][XLEN-1:0]         req_src2,
  input  logic [1:0][XLEN-1:0]         req_imm,
  input  logic [1:0][SHAMT_W-1:0]      req_shamt,
  output logic [1:0]                   rsp_valid,
  input  logic [1:0]                   rsp_ready,
  output logic [XLEN-1:0]              rsp_data,
  output logic                         rsp_err,
  output logic [OP_W-1:0]              alu_cntrl,
  output logic [XLEN-1:0]              alu_src1,
  output logic [XLEN-1:0]              alu_src2,
  output logic [XLEN-1:0]              alu_imm,
  output logic [SHAMT_W-1:0]           alu_shamt,
  input  logic [XLEN-1:0]              alu_result,
  output logic                         busy
);

  seq_state_e          state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [XLEN-1:0]     src1_q, src1_d, src2_q, src2_d, imm_q, imm_d;
  logic [SHAMT_W-1:0]  shamt_q, shamt_d;
  logic                owner_q, owner_d;
  logic [XLEN-1:0]     rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic [1:0] gnt;
  logic       idle, hs, win, legal;

  assign idle = (state_q == IDLE);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_valid),
    .hs_i  (hs),
    .gnt_o (gnt)
  );

  // req_ready depends only on state, arbiter priority and req_valid.
  assign req_ready = idle ? gnt : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign win       = gnt[1];
  // Legal set is defined on the 6-bit code; OP_W is expected to be 6.
  assign legal     = is_legal_op(6'(op_q));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    imm_d      = imm_q;
    shamt_d    = shamt_q;
    owner_d    = owner_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          op_d    = req_op[win];
          src1_d  = req_src1[win];
          src2_d  = req_src2[win];
          imm_d   = req_imm[win];
          shamt_d = req_shamt[win];
          owner_d = win;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Illegal codes return 0 regardless of what the ALU produced.
        rsp_err_d  = ~legal;
        rsp_data_d = legal ? alu_result : '0;
        state_d    = RESP;
      end
      RESP: begin
        // The non-owner rsp_ready bit is deliberately ignored.
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      imm_q      <= '0;
      shamt_q    <= '0;
      owner_q    <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      imm_q      <= imm_d;
      shamt_q    <= shamt_d;
      owner_q    <= owner_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // ALU sees the latched operation only in EXEC; otherwise a quiet NOP
  // so the shared ALU does not toggle.
  assign alu_cntrl = (state_q == EXEC) ? op_q    : {OP_W{1'b1}};
  assign alu_src1  = (state_q == EXEC) ? src1_q  : '0;
  assign alu_src2  = (state_q == EXEC) ? src2_q  : '0;
  assign alu_imm   = (state_q == EXEC) ? imm_q   : '0;
  assign alu_shamt = (state_q == EXEC) ? shamt_q : '0;

  for (genvar g = 0; g < 2; g++) begin : g_rsp
    assign rsp_valid[g] = (state_q == RESP) && (owner_q == 1'(g));
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign busy     = ~idle;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  localparam int XLEN = 32, OP_W = 6, SHAMT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]                 req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][OP_W-1:0]       req_op;
  logic [1:0][XLEN-1:0]       req_src1, req_src2, req_imm;
  logic [1:0][SHAMT_W-1:0]    req_shamt;
  logic [XLEN-1:0]            rsp_data, alu_src1, alu_src2, alu_imm, alu_result;
  logic                       rsp_err, busy;
  logic [OP_W-1:0]            alu_cntrl;
  logic [SHAMT_W-1:0]         alu_shamt;

  alu_op_sequencer #(.XLEN(XLEN), .OP_W(OP_W), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_imm(req_imm), .req_shamt(req_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_cntrl(alu_cntrl), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_imm(alu_imm),
    .alu_shamt(alu_shamt), .alu_result(alu_result), .busy(busy)
  );

  // Stand-in for the shared ALU. Undefined codes return a non-zero
  // pattern so that zero-forcing of illegal ops is observable.
  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a, b, imm,
                                         input logic [3:0] sh);
    case (op)
      6'h00: return a + b;
      6'h01: return a - b;
      6'h02: return a << b[4:0];
      6'h03: return {31'b0, $signed(a) < $signed(b)};
      6'h04: return {31'b0, a < b};
      6'h05: return a ^ b;
      6'h06: return a >> b[4:0];
      6'h07: return 32'($signed(a) >>> b[4:0]);
      6'h08: return a | b;
      6'h09: return a & b;
      6'h0A: return a + imm;
      6'h0B: return a << sh;
      6'h0C: return {31'b0, $signed(a) < $signed(imm)};
      6'h0D: return {31'b0, a < imm};
      6'h0E: return a ^ imm;
      6'h0F: return a >> sh;
      6'h10: return a | imm;
      6'h11: return a & imm;
      6'h12: return imm << 12;
      6'h1A: return {31'b0, a == b};
      6'h1B: return {31'b0, a != b};
      6'h1C: return {31'b0, $signed(a) < $signed(b)};
      6'h1D: return {31'b0, $signed(a) >= $signed(b)};
      6'h3F: return 32'h0;
      default: return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_cntrl, alu_src1, alu_src2, alu_imm, alu_shamt);

  function automatic bit ref_legal(input int op);
    return (op <= 18) || (op >= 26 && op <= 29);
  endfunction

  // Reference model state: pending requests per port and last winner.
  logic [1:0]  pend;
  logic [5:0]  p_op [2];
  logic [31:0] p_s1 [2], p_s2 [2], p_imm [2];
  logic [3:0]  p_sh [2];
  int          last_w;
  int          n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [5:0] op, input logic [31:0] s1, s2, im,
                         input logic [3:0] sh);
    pend[p] = 1'b1; p_op[p] = op; p_s1[p] = s1; p_s2[p] = s2; p_imm[p] = im; p_sh[p] = sh;
  endtask

  task automatic drive_reqs();
    req_valid = pend;
    for (int p = 0; p < 2; p++) begin
      req_op[p] = p_op[p]; req_src1[p] = p_s1[p]; req_src2[p] = p_s2[p];
      req_imm[p] = p_imm[p]; req_shamt[p] = p_sh[p];
    end
  endtask

  // One full transaction from an IDLE cycle; owner's rsp_ready is held
  // low for 'hold' RESP cycles. Returns observed grant and completion data.
  task automatic serve(input int hold, output int gnt, output logic [31:0] rd, output logic re);
    int w;
    logic [5:0] op; logic [31:0] s1, s2, im, exp_d; logic [3:0] sh; logic exp_e;
    w = (pend == 2'b11) ? ((last_w == 1) ? 0 : 1) : (pend[1] ? 1 : 0);
    drive_reqs();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_rsp_valid", rsp_valid, 0);
    check("grant", req_ready, 64'd1 << w);
    gnt = req_ready[1] ? 1 : 0;
    op = p_op[w]; s1 = p_s1[w]; s2 = p_s2[w]; im = p_imm[w]; sh = p_sh[w];
    exp_e = !ref_legal(int'(op));
    exp_d = exp_e ? 32'h0 : alu_fn(op, s1, s2, im, sh);
    pend[w] = 1'b0; last_w = w;
    @(posedge clk); #1; drive_reqs();
    @(negedge clk);
    check("exec_busy", busy, 1);
    check("exec_req_ready", req_ready, 0);
    check("exec_rsp_valid", rsp_valid, 0);
    check("exec_cntrl", alu_cntrl, op);
    check("exec_src1", alu_src1, s1);
    check("exec_src2", alu_src2, s2);
    check("exec_imm", alu_imm, im);
    check("exec_shamt", alu_shamt, sh);
    @(posedge clk); #1;
    rd = '0; re = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = 2'b00;
      rsp_ready[1-w] = 1'($urandom_range(0, 1));
      rsp_ready[w] = (h == hold);
      @(negedge clk);
      check("rsp_valid", rsp_valid, 64'd1 << w);
      check("rsp_data", rsp_data, exp_d);
      check("rsp_err", rsp_err, exp_e);
      check("rsp_req_ready", req_ready, 0);
      check("rsp_busy", busy, 1);
      rd = rsp_data; re = rsp_err;
      @(posedge clk); #1;
    end
    rsp_ready = 2'b00;
  endtask

  initial begin
    int g;
    logic [31:0] rd;
    logic re;
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    req_op = '0; req_src1 = '0; req_src2 = '0; req_imm = '0; req_shamt = '0;
    pend = '0; last_w = 1;
    for (int p = 0; p < 2; p++) begin
      p_op[p] = '0; p_s1[p] = '0; p_s2[p] = '0; p_imm[p] = '0; p_sh[p] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_cntrl", alu_cntrl, 6'h3F);
    check("rst_alu_ops", {alu_src1, alu_src2}, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Single ADD on port 0
    set_req(0, 6'h00, 32'd5, 32'd7, 32'd0, 4'd0);
    serve(0, g, rd, re);
    check("add_gnt", g, 0);
    check("add_data", rd, 12);

    // Branch compare on port 1 (also leaves port 1 as last winner)
    set_req(1, 6'h1A, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 4'd0);
    serve(0, g, rd, re);
    check("beq_gnt", g, 1);
    check("beq_data", rd, 1);

    // Tie, both ports continuously valid: grants 0,1,0
    set_req(0, 6'h01, 32'd10, 32'd3, 32'd0, 4'd0);
    set_req(1, 6'h05, 32'hF0, 32'h0F, 32'd0, 4'd0);
    serve(0, g, rd, re); check("tie1_gnt", g, 0); check("tie1_data", rd, 7);
    set_req(0, 6'h01, 32'd10, 32'd3, 32'd0, 4'd0);
    serve(0, g, rd, re); check("tie2_gnt", g, 1); check("tie2_data", rd, 32'hFF);
    set_req(1, 6'h05, 32'hF0, 32'h0F, 32'd0, 4'd0);
    serve(0, g, rd, re); check("tie3_gnt", g, 0); check("tie3_data", rd, 7);
    serve(0, g, rd, re); check("tie4_gnt", g, 1);

    // Back-pressure: owner holds rsp_ready low 5 cycles, other port waiting
    set_req(0, 6'h08, 32'h1234, 32'hF000, 32'd0, 4'd0);
    set_req(1, 6'h0A, 32'd100, 32'd0, 32'd23, 4'd0);
    serve(5, g, rd, re); check("bp_gnt", g, 0); check("bp_data", rd, 32'hF234);
    serve(0, g, rd, re); check("bp_next_data", rd, 123);

    // Illegal opcode, then a legal one
    set_req(0, 6'h15, 32'h55, 32'h66, 32'd0, 4'd0);
    serve(1, g, rd, re); check("ill_err", re, 1); check("ill_data", rd, 0);
    set_req(0, 6'h03, 32'hFFFFFFFF, 32'd1, 32'd0, 4'd0);
    serve(0, g, rd, re); check("after_ill_err", re, 0); check("after_ill_data", rd, 1);

    // Reset during EXEC (port 0 wins, so last_grant is 0 before reset)
    set_req(0, 6'h00, 32'd1, 32'd2, 32'd0, 4'd0);
    drive_reqs();
    @(negedge clk); check("mid_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    pend = '0; req_valid = '0; last_w = 0; rst_n = 1'b0;
    @(negedge clk); check("mid_exec_cntrl", alu_cntrl, 6'h00);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cntrl", alu_cntrl, 6'h3F);
    check("mid_rst_src", {alu_src1, alu_src2}, 0);
    check("mid_rst_data", {rsp_err, rsp_data}, 0);
    @(posedge clk); #1; rst_n = 1'b1; last_w = 1;
    repeat (3) begin
      @(negedge clk);
      check("abandon_rsp_valid", rsp_valid, 0);
      check("abandon_busy", busy, 0);
      @(posedge clk); #1;
    end
    // last_grant back to 1: port 0 wins the first tie again
    set_req(0, 6'h09, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 4'd0);
    set_req(1, 6'h12, 32'd0, 32'd0, 32'h00ABC, 4'd0);
    serve(0, g, rd, re); check("post_rst_tie_gnt", g, 0);
    serve(0, g, rd, re); check("lui_data", rd, 32'h00ABC000);

    // Randomized traffic against the reference model
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && ($urandom_range(0, 1) == 1))
          set_req(p, ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom_range(0, 31)),
                  $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  $urandom, 4'($urandom_range(0, 15)));
      if (pend == 2'b00)
        set_req(it % 2, 6'($urandom_range(0, 29)), $urandom, $urandom, $urandom,
                4'($urandom_range(0, 15)));
      serve($urandom_range(0, 3), g, rd, re);
    end
    while (pend != 2'b00) serve(0, g, rd, re);

    @(negedge clk);
    check("final_idle", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
